// File: rtl/display_spi_queue_if.sv
// Host-side command interface for display_spi_queue: push handshake plus
// queue status. FIFO_DEPTH must match the attached queue so the level
// field has the right width.
interface display_spi_queue_if #(
  parameter int FIFO_DEPTH = 16
) ();
  logic [1:0]                  dspi_cmd;
  logic [7:0]                  dspi_byte;
  logic                        dspi_valid;
  logic                        dspi_ready;
  logic                        dspi_idle;
  logic [$clog2(FIFO_DEPTH):0] dspi_level;

  modport master (
    output dspi_cmd, dspi_byte, dspi_valid,
    input  dspi_ready, dspi_idle, dspi_level
  );

  modport slave (
    input  dspi_cmd, dspi_byte, dspi_valid,
    output dspi_ready, dspi_idle, dspi_level
  );
endinterface

// File: rtl/display_spi_queue.sv
// Display SPI command queue: a FIFO of {cmd, byte} entries drained by an
// engine that drives a mode-0, MSB-first SPI panel plus its reset pin.
// Optional macro DSPI_BURST_CS_EN: consecutive SEND_* entries share one
// chip-select window instead of a GAP between every byte.
module display_spi_queue #(
  parameter int CLK_DIV    = 11,
  parameter int FIFO_DEPTH = 16,
  parameter int RST_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  display_spi_queue_if.slave  bus,
  output logic                spi_din,
  output logic                spi_clk,
  output logic                spi_cs,
  output logic                spi_dc,
  output logic                spi_rst
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(2*CLK_DIV - 1);
  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [1:0]  CMD_NONE      = 2'b00;
  localparam logic [1:0]  CMD_RESET     = 2'b01;
  localparam logic [1:0]  CMD_SEND_DATA = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, RST_LOW, RST_WAIT} state_t;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          ready, push, pop;
  logic [9:0]    head;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  half, half_n;
  logic [7:0]  sr, sr_n;
  logic        sclk_nx, cs_nx, dc_nx, din_nx, srst_nx;

  assign ready          = (level != FULL);
  assign push           = bus.dspi_valid && ready && (bus.dspi_cmd != CMD_NONE);
  assign head           = mem[rd_ptr];
  assign bus.dspi_ready = ready;
  assign bus.dspi_level = level;
  assign bus.dspi_idle  = (state == IDLE) && (level == '0);

  // Queue storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.dspi_cmd, bus.dspi_byte};
  end

  // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // Engine state and registered panel pins (pins follow the state being entered).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      half    <= '0;
      sr      <= '0;
      spi_clk <= 1'b0;
      spi_cs  <= 1'b1;
      spi_dc  <= 1'b0;
      spi_din <= 1'b0;
      spi_rst <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      half    <= half_n;
      sr      <= sr_n;
      spi_clk <= sclk_nx;
      spi_cs  <= cs_nx;
      spi_dc  <= dc_nx;
      spi_din <= din_nx;
      spi_rst <= srst_nx;
    end
  end

  // Next-state and next-pin decode; half counts the 16 spi_clk half-periods of a byte.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    half_n  = half;
    sr_n    = sr;
    sclk_nx = spi_clk;
    cs_nx   = spi_cs;
    dc_nx   = spi_dc;
    din_nx  = spi_din;
    srst_nx = spi_rst;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop   = 1'b1;
          cnt_n = '0;
          if (head[9:8] == CMD_RESET) begin
            state_n = RST_LOW;
            srst_nx = 1'b0;
          end else begin
            state_n = LOAD;
            cs_nx   = 1'b0;
            sclk_nx = 1'b0;
            dc_nx   = (head[9:8] == CMD_SEND_DATA);
            din_nx  = head[7];
            sr_n    = head[7:0];
          end
        end
      end
      LOAD: begin
        state_n = SHIFT;
        cnt_n   = '0;
        half_n  = '0;
      end
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_n   = '0;
          half_n  = half + 4'd1;
          sclk_nx = ~spi_clk;
          // Data only moves on the falling edge so the panel samples a settled bit.
          if (spi_clk) begin
            sr_n   = {sr[6:0], 1'b0};
            din_nx = sr[6];
          end
          if (half == 4'd15) begin
            state_n = GAP;
            cs_nx   = 1'b1;
            din_nx  = 1'b0;
`ifdef DSPI_BURST_CS_EN
            // Chain the next SEND_* with chip select held; dc moves while spi_clk is low.
            if (level != '0 && head[9]) begin
              pop     = 1'b1;
              state_n = LOAD;
              cs_nx   = 1'b0;
              dc_nx   = (head[9:8] == CMD_SEND_DATA);
              din_nx  = head[7];
              sr_n    = head[7:0];
            end
`endif
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      RST_LOW: begin
        if (cnt == RST_LAST) begin
          state_n = RST_WAIT;
          srst_nx = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      RST_WAIT: begin
        if (cnt == RST_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_display_spi_queue.sv
// Bench for display_spi_queue: a frame-timeline model predicts every output
// each cycle, a pin decoder scoreboards transmitted bytes, and directed plus
// random pushes exercise reset, RESET command, full queue, burst and wrap.
module tb_display_spi_queue;
  localparam int D = 2, DEPTH = 4, R = 8;
  localparam int SHIFT_END = 16*D + 1;   // last frame offset with cs low
  localparam int SEND_END  = 18*D + 1;   // last frame offset of a SEND (end of GAP)
`ifdef DSPI_BURST_CS_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct packed { logic [1:0] cmd; logic [7:0] b; } ent_t;

  logic clk = 1'b0, rst_n = 1'b1;
  logic spi_din, spi_clk, spi_cs, spi_dc, spi_rst;
  int total = 0, bad = 0;

  display_spi_queue_if #(.FIFO_DEPTH(DEPTH)) bus ();

  display_spi_queue #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH), .RST_CYCLES(R)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .spi_din(spi_din), .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_dc(spi_dc), .spi_rst(spi_rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: queue plus a per-frame offset timeline ----------------
  ent_t mq[$], exp_tx[$], mcur;
  bit   mbusy = 0, mdc = 0;
  int   moff = 0;

  function automatic void start_frame();
    mcur  = mq.pop_front();
    mbusy = 1;
    moff  = 1;
    if (mcur.cmd[1]) mdc = (mcur.cmd == 2'b11);
  endfunction

  initial begin
    int lvl; bit acc; ent_t pe;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete(); exp_tx.delete(); mbusy = 0; moff = 0; mdc = 0;
      end else begin
        lvl = mq.size();
        acc = bus.dspi_valid && bus.dspi_cmd != 2'b00 && lvl < DEPTH;
        pe  = '{bus.dspi_cmd, bus.dspi_byte};
        if (!mbusy) begin
          if (lvl > 0) start_frame();
        end else if (mcur.cmd == 2'b01) begin
          if (moff == 2*R) mbusy = 0; else moff++;
        end else if (BURST && moff == SHIFT_END && lvl > 0 && mq[0].cmd[1]) begin
          start_frame();
        end else if (moff == SEND_END) begin
          mbusy = 0;
        end else begin
          moff++;
        end
        if (acc) begin
          mq.push_back(pe);
          if (pe.cmd[1]) exp_tx.push_back(pe);
        end
      end
    end
  end

  // ---------------- per-cycle compare plus pin decoder ----------------
  int nb = 0, rx_cnt = 0, cs_run = 0, rst_run = 0, last_cs = 0, max_cs = 0, last_rst = 0;
  logic [7:0] sh = '0, last_rx = '0;
  logic pclk = 1'b0, last_dc = 1'b0;

  initial begin
    int k; bit e_cs, e_clk, e_din, e_rst; logic [9:0] got, want; ent_t e;
    forever begin
      @(negedge clk);
      e_cs = 1; e_clk = 0; e_din = 0; e_rst = 1;
      if (mbusy && mcur.cmd == 2'b01) e_rst = (moff > R);
      else if (mbusy && moff <= SHIFT_END) begin
        e_cs = 0;
        if (moff == 1) e_din = mcur.b[7];
        else begin
          k = moff - 2;
          e_clk = ((k / D) % 2) == 1;
          e_din = mcur.b[7 - k/(2*D)];
        end
      end
      got  = {bus.dspi_level, bus.dspi_ready, bus.dspi_idle, spi_cs, spi_clk, spi_din, spi_dc, spi_rst};
      want = {3'(mq.size()), mq.size() < DEPTH, !mbusy && mq.size() == 0, e_cs, e_clk, e_din, mdc, e_rst};
      chk("cycle", {22'd0, got}, {22'd0, want});

      if (!rst_n) begin
        nb = 0; cs_run = 0; rst_run = 0; pclk = 0;
      end else begin
        if (!spi_cs && spi_clk && !pclk) begin
          sh = {sh[6:0], spi_din};
          nb++;
          if (nb == 8) begin
            nb = 0; rx_cnt++; last_rx = sh; last_dc = spi_dc;
            if (exp_tx.size() == 0) chk("rx_extra", 1, 0);
            else begin
              e = exp_tx.pop_front();
              chk("rx_byte", {23'd0, spi_dc, sh}, {23'd0, e.cmd == 2'b11, e.b});
            end
          end
        end
        if (spi_cs) nb = 0;
        if (!spi_cs) cs_run++;
        else if (cs_run > 0) begin
          last_cs = cs_run;
          if (cs_run > max_cs) max_cs = cs_run;
          cs_run = 0;
        end
        if (!spi_rst) rst_run++;
        else if (rst_run > 0) begin last_rst = rst_run; rst_run = 0; end
        pclk = spi_clk;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic quiet();
    bus.dspi_valid = 1'b0; bus.dspi_cmd = 2'b00; bus.dspi_byte = 8'h00;
  endtask

  task automatic put(input logic [1:0] c, input logic [7:0] b);
    bus.dspi_valid = 1'b1; bus.dspi_cmd = c; bus.dspi_byte = b;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk); @(negedge clk);
    while (!bus.dspi_idle && n < 3000) begin @(negedge clk); n++; end
    chk(nm, n < 3000, 1);
  endtask

  initial begin
    int r0, acc, guard, r; logic [1:0] c; logic v;
    quiet();
    #2 rst_n = 1'b0;
    #1 chk("reset_pins", {bus.dspi_level, bus.dspi_ready, bus.dspi_idle, spi_cs, spi_clk, spi_din, spi_dc, spi_rst},
           10'b000_1_1_1_0_0_0_1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single SEND_COMMAND 0xAE
    put(2'b10, 8'hAE); quiet();
    wait_idle("t2_idle");
    chk("t2_byte", last_rx, 8'hAE);
    chk("t2_dc", last_dc, 0);
    chk("t2_cs_low", last_cs, 33);

    // RESET then SEND_DATA 0x55
    put(2'b01, 8'h00); put(2'b11, 8'h55); quiet();
    wait_idle("t3_idle");
    chk("t3_rst_low", last_rst, R);
    chk("t3_byte", last_rx, 8'h55);
    chk("t3_dc", last_dc, 1);

    // fill the queue behind a RESET; fifth push must drop
    r0 = rx_cnt;
    put(2'b01, 8'h00);
    put(2'b10, 8'h11); put(2'b11, 8'h22); put(2'b10, 8'h33); put(2'b11, 8'h44);
    put(2'b10, 8'h55); quiet();
    chk("t4_level", bus.dspi_level, 4);
    chk("t4_ready", bus.dspi_ready, 0);
    wait_idle("t4_idle");
    chk("t4_count", rx_cnt - r0, 4);
    chk("t4_last", last_rx, 8'h44);

    // two bytes: one cs window in burst builds, two otherwise
    max_cs = 0;
    put(2'b10, 8'hAA); put(2'b11, 8'h01); quiet();
    wait_idle("t5_idle");
    chk("t5_cs_run", max_cs, BURST ? 66 : 33);
    chk("t5_last", {last_dc, last_rx}, 9'h101);

    // reset in the middle of a byte
    put(2'b10, 8'hF0); quiet();
    guard = 0;
    while (nb < 4 && guard < 400) begin @(negedge clk); guard++; end
    chk("t6_reach_bit4", guard < 400, 1);
    #3 rst_n = 1'b0;
    #1 chk("t6_abort", {spi_cs, spi_clk, bus.dspi_level, bus.dspi_ready, bus.dspi_idle}, 7'b1_0_000_1_1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    put(2'b11, 8'h3C); quiet();
    wait_idle("t6_idle");
    chk("t6_byte", last_rx, 8'h3C);

    // random traffic until 40 SEND bytes are accepted
    r0 = rx_cnt; acc = 0; guard = 0;
    while (acc < 40 && guard < 20000) begin
      r = $urandom_range(0, 15);
      v = ($urandom_range(0, 3) != 0);
      c = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r[0] ? 2'b10 : 2'b11);
      if (v && c[1] && bus.dspi_ready) acc++;
      bus.dspi_valid = v; bus.dspi_cmd = c; bus.dspi_byte = 8'($urandom);
      @(negedge clk);
      guard++;
    end
    quiet();
    chk("t7_accepted", acc, 40);
    wait_idle("t7_idle_wait");
    chk("t7_rx", rx_cnt - r0, 40);
    chk("t7_left", exp_tx.size(), 0);
    chk("t7_idle", bus.dspi_idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
